// File: rtl/mul_div_x32.sv
// 32-bit iterative multiplier / restoring divider sharing one 33-bit add/sub.
// Optional MULDIV_SIGNED_EN adds i_signed for two's-complement operands.
module mul_div_x32 (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_op,
`ifdef MULDIV_SIGNED_EN
  input  logic        i_signed,
`endif
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_opnd;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_sgn;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_x;
  logic [32:0] w_y;
  logic [32:0] w_res;
  logic        w_cout;
  logic        w_borrow;
  logic [63:0] w_prod_neg;
  logic [31:0] w_fin_hi;
  logic [31:0] w_fin_lo;

`ifdef MULDIV_SIGNED_EN
  assign w_sgn = i_signed;
`else
  assign w_sgn = 1'b0;
`endif

  // Signed operands are iterated as magnitudes; signs are reapplied at FIN.
  assign w_a_neg = w_sgn & i_a[31];
  assign w_b_neg = w_sgn & i_b[31];
  assign w_a_mag = w_a_neg ? (~i_a + 32'd1) : i_a;
  assign w_b_mag = w_b_neg ? (~i_b + 32'd1) : i_b;

  // Shared adder: multiply adds into the upper half, divide trial-subtracts
  // from the left-shifted remainder; carry-out low on subtract means borrow.
  assign w_x = r_op ? {r_hi, r_lo[31]} : {1'b0, r_hi};
  assign w_y = {1'b0, r_opnd};
  assign {w_cout, w_res} = {1'b0, w_x} + {1'b0, (r_op ? ~w_y : w_y)} + {33'd0, r_op};
  assign w_borrow = r_op & ~w_cout;

  assign w_prod_neg = ~{r_hi, r_lo} + 64'd1;

  always_comb begin
    w_fin_hi = r_hi;
    w_fin_lo = r_lo;
    if (r_op) begin
      if (r_neg_r) w_fin_hi = ~r_hi + 32'd1;
      if (r_neg_q) w_fin_lo = ~r_lo + 32'd1;
    end else if (r_neg_q) begin
      w_fin_hi = w_prod_neg[63:32];
      w_fin_lo = w_prod_neg[31:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_op          <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_opnd        <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_hi          <= '0;
      o_lo          <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_op && (i_b == '0)) begin
              o_done        <= 1'b1;
              o_hi          <= i_a;
              o_lo          <= '1;
              o_div_by_zero <= 1'b1;
            end else begin
              r_op          <= i_op;
              r_cnt         <= '0;
              r_hi          <= '0;
              r_lo          <= i_op ? w_a_mag : w_b_mag;
              r_opnd        <= i_op ? w_b_mag : w_a_mag;
              r_neg_q       <= w_a_neg ^ w_b_neg;
              r_neg_r       <= i_op & w_a_neg;
              o_busy        <= 1'b1;
              o_div_by_zero <= 1'b0;
              r_state       <= RUN;
            end
          end
        end
        RUN: begin
          if (r_op) begin
            if (!w_borrow) begin
              r_hi <= w_res[31:0];
              r_lo <= {r_lo[30:0], 1'b1};
            end else begin
              r_hi <= {r_hi[30:0], r_lo[31]};
              r_lo <= {r_lo[30:0], 1'b0};
            end
          end else if (r_lo[0]) begin
            {r_hi, r_lo} <= {w_res, r_lo[31:1]};
          end else begin
            {r_hi, r_lo} <= {1'b0, r_hi, r_lo[31:1]};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            o_busy  <= 1'b0;
            r_state <= FIN;
          end
        end
        FIN: begin
          o_done  <= 1'b1;
          o_hi    <= w_fin_hi;
          o_lo    <= w_fin_lo;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_x32.sv
// Self-checking bench for mul_div_x32: vector table plus hand-written
// sequences for ignored Start, back-to-back, divide-by-zero and mid-run reset.
module tb_mul_div_x32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
`ifdef MULDIV_SIGNED_EN
  logic        sgn = 1'b0;
`endif
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_dbz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];

  mul_div_x32 dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_op          (op),
`ifdef MULDIV_SIGNED_EN
    .i_signed      (sgn),
`endif
    .i_a           (a),
    .i_b           (b),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_hi          (o_hi),
    .o_lo          (o_lo),
    .o_div_by_zero (o_dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one operation on the next edge and checks its completion.
  // pulse_at >= 0 raises a conflicting Start for one edge while busy.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int pulse_at, input string name);
    exp_t e;
    int   n;
    int   busy_cnt;
    e.hi  = ehi;
    e.lo  = elo;
    e.dbz = edbz;
    e.lat = (o && (y == 32'd0)) ? 0 : 33;
    sb.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    tick;
    start = 1'b0;
    op = ~o; a = $urandom; b = $urandom;
    if (e.lat != 0) begin
      chk({name, "_busy_start"}, 64'(o_busy), 64'd1);
      chk({name, "_done_low"},   64'(o_done), 64'd0);
      chk({name, "_dbz_clear"},  64'(o_dbz),  64'd0);
    end
    n = 0;
    busy_cnt = o_busy ? 1 : 0;
    while (!o_done && n < 40) begin
      if (n == pulse_at) begin
        start = 1'b1; op = 1'b1; a = 32'd99; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick;
      n++;
      if (o_busy) busy_cnt++;
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!o_done) begin
      chk({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({name, "_hi"},      64'(o_hi),   64'(e.hi));
      chk({name, "_lo"},      64'(o_lo),   64'(e.lo));
      chk({name, "_dbz"},     64'(o_dbz),  64'(e.dbz));
      chk({name, "_latency"}, 64'(n),      64'(e.lat));
      chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'((e.lat == 0) ? 0 : 32));
      chk({name, "_busy_done"},   64'(o_busy),   64'd0);
    end
  endtask

  initial begin
    vec_t v;
    int   dn;
    vt.push_back('{1'b0, 32'd1,         32'd7,         32'd0,         32'd7,         1'b0});
    vt.push_back('{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  32'h00000001,  1'b0});
    vt.push_back('{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0});
    vt.push_back('{1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFFFFFF,  1'b1});
    vt.push_back('{1'b0, 32'd0,         32'd12345,     32'd0,         32'd0,         1'b0});
    vt.push_back('{1'b1, 32'd7,         32'd9,         32'd7,         32'd0,         1'b0});
    vt.push_back('{1'b1, 32'hFFFFFFFF,  32'd1,         32'd0,         32'hFFFFFFFF,  1'b0});
    vt.push_back('{1'b0, 32'h80000000,  32'd2,         32'd1,         32'd0,         1'b0});
    vt.push_back('{1'b1, 32'd0,         32'd0,         32'd0,         32'hFFFFFFFF,  1'b1});
    vt.push_back('{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         32'd1,         1'b0});
    for (int i = 0; i < 4; i++) begin
      logic [63:0] p;
      v.op = i[0];
      v.a  = $urandom;
      v.b  = ($urandom >> $urandom_range(0, 31)) | 32'd1;
      p    = 64'(v.a) * 64'(v.b);
      v.hi = v.op ? (v.a % v.b) : p[63:32];
      v.lo = v.op ? (v.a / v.b) : p[31:0];
      v.dbz = 1'b0;
      vt.push_back(v);
    end

    #3 rst_n = 1'b0;
    tick;
    tick;
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_done", 64'(o_done), 64'd0);
    chk("reset_hi",   64'(o_hi),   64'd0);
    chk("reset_lo",   64'(o_lo),   64'd0);
    chk("reset_dbz",  64'(o_dbz),  64'd0);
    rst_n = 1'b1;

    // Consecutive calls start on the edge right after Done: back-to-back.
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      run_op(v.op, v.a, v.b, v.hi, v.lo, v.dbz, -1, $sformatf("vec%0d", i));
    end

    run_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 10, "ignore_start");
    run_op(1'b1, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, -1, "after_ignore");

`ifdef MULDIV_SIGNED_EN
    sgn = 1'b1;
    run_op(1'b1, 32'hFFFFFFFA, 32'd4, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, -1, "sdiv_m6_4");
    run_op(1'b0, 32'hFFFFFFFA, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEE, 1'b0, -1, "smul_m6_3");
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, -1, "sdiv_7_m2");
    run_op(1'b1, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, -1, "sdiv_zero");
    sgn = 1'b0;
`endif

    op = 1'b0; a = 32'h1234; b = 32'h10; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_done", 64'(o_done), 64'd0);
    chk("midrst_hi",   64'(o_hi),   64'd0);
    chk("midrst_lo",   64'(o_lo),   64'd0);
    chk("midrst_dbz",  64'(o_dbz),  64'd0);
    tick;
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      tick;
      if (o_done) dn++;
    end
    chk("midrst_no_done", 64'(dn), 64'd0);
    run_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, -1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
